// File: rtl/timer_pkg.sv
// Shared constants for the 8-bit APB timer: prescale selects, TCR/TSR bit positions.
package timer_pkg;

    localparam int unsigned CKS_W = 2;

    localparam logic [CKS_W-1:0] CKS_DIV2  = 2'b00;
    localparam logic [CKS_W-1:0] CKS_DIV4  = 2'b01;
    localparam logic [CKS_W-1:0] CKS_DIV8  = 2'b10;
    localparam logic [CKS_W-1:0] CKS_DIV16 = 2'b11;

    localparam int unsigned TCR_LOAD    = 7;
    localparam int unsigned TCR_UPDN    = 5;
    localparam int unsigned TCR_EN      = 4;
    localparam int unsigned TCR_CKS_LSB = 0;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

endpackage : timer_pkg

// File: rtl/timer_counter_core_if.sv
// Register-file <-> counting-engine signal bundle.
interface timer_counter_core_if
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] tdr;
    logic             load;
    logic             up_down;
    logic             en;
    logic [CKS_W-1:0] cks;
    logic [WIDTH-1:0] cnt;
    logic             ovf_set;
    logic             udf_set;

    modport master (
        output tdr, load, up_down, en, cks,
        input  cnt, ovf_set, udf_set
    );

    modport slave (
        input  tdr, load, up_down, en, cks,
        output cnt, ovf_set, udf_set
    );
endinterface : timer_counter_core_if

// File: rtl/timer_prescaler.sv
// Free-running prescale counter; tick marks the last cycle of each /2../16 period.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W = 4
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             en,
    input  logic             clr,
    input  logic [CKS_W-1:0] cks,
    output logic             tick
);
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] mask_c;

    // Low (cks+1) bits select the division ratio.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(DIV_W); i++) begin
            mask_c[i] = (i <= int'(cks));
        end
    end

    assign tick = ((div_cnt_q & mask_c) == mask_c);

    always_comb begin
        div_cnt_d = '0;
        if (en && !clr) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
endmodule : timer_prescaler

// File: rtl/timer_counter_core.sv
// Counting engine of the APB timer: loadable prescaled up/down counter with wrap pulses.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 4
) (
    input  logic                 pclk,
    input  logic                 presetn,
    timer_counter_core_if.slave  bus
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_set_q;
    logic             ovf_set_d;
    logic             udf_set_q;
    logic             udf_set_d;
    logic             tick;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (bus.en),
        .clr     (bus.load),
        .cks     (bus.cks),
        .tick    (tick)
    );

    // Load beats counting; direction is sampled only on the tick cycle.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_d = 1'b0;
        udf_set_d = 1'b0;
        if (bus.load) begin
            cnt_d = bus.tdr;
        end else if (bus.en && tick) begin
            if (!bus.up_down) begin
                cnt_d     = cnt_q + WIDTH'(1);
                ovf_set_d = (cnt_q == {WIDTH{1'b1}});
            end else begin
                cnt_d     = cnt_q - WIDTH'(1);
                udf_set_d = (cnt_q == '0);
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q     <= '0;
            ovf_set_q <= 1'b0;
            udf_set_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ovf_set_q <= ovf_set_d;
            udf_set_q <= udf_set_d;
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.ovf_set = ovf_set_q;
    assign bus.udf_set = udf_set_q;
endmodule : timer_counter_core

// File: tb/tb_timer_counter_core.sv
// Randomized + directed bench for timer_counter_core against a cycle-count reference model.
module tb_timer_counter_core;
    logic pclk    = 1'b0;
    logic presetn = 1'b0;

    timer_counter_core_if #(.WIDTH(8)) bus ();

    timer_counter_core #(
        .WIDTH (8),
        .DIV_W (4)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.slave)
    );

    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: counter value, enabled-cycle count since last clear, pulses.
    int m_cnt = 0;
    int m_k   = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_cnt = 0; m_k = 0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            int n;
            bit tk;
            n     = 2 << bus.cks;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            if (bus.load) begin
                m_cnt = int'(bus.tdr);
                m_k   = 0;
            end else if (bus.en) begin
                tk  = ((m_k % n) == n - 1);
                m_k = m_k + 1;
                if (tk) begin
                    if (!bus.up_down) begin
                        m_ovf = (m_cnt == 255);
                        m_cnt = (m_cnt + 1) % 256;
                    end else begin
                        m_udf = (m_cnt == 0);
                        m_cnt = (m_cnt + 255) % 256;
                    end
                end
            end else begin
                m_k = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge pclk) begin
        chk("cnt_vs_model", int'(bus.cnt), m_cnt);
        chk("ovf_vs_model", int'(bus.ovf_set), int'(m_ovf));
        chk("udf_vs_model", int'(bus.udf_set), int'(m_udf));
        chk("pulse_exclusive", int'(bus.ovf_set & bus.udf_set), 0);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk);
            @(negedge pclk);
        end
    endtask

    // Literal expectation applied to both DUT and model.
    task automatic expect_state(input string name, input int c, input int o, input int u);
        chk({name, "_cnt"}, int'(bus.cnt), c);
        chk({name, "_ovf"}, int'(bus.ovf_set), o);
        chk({name, "_udf"}, int'(bus.udf_set), u);
        chk({name, "_model"}, m_cnt, c);
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.en   = 1'b0;
        bus.tdr  = v;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
    endtask

    initial begin
        bus.tdr = 8'h77; bus.load = 1'b1; bus.up_down = 1'b0; bus.en = 1'b1; bus.cks = 2'b00;
        @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            expect_state("reset_hold", 0, 0, 0);
            step(1);
        end
        presetn = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0;
        step(3);
        expect_state("idle_after_reset", 0, 0, 0);

        do_load(8'hA5);
        expect_state("load_a5", 8'hA5, 0, 0);
        bus.tdr = 8'h3C;
        step(2);
        expect_state("tdr_change_no_load", 8'hA5, 0, 0);

        // Up /2 through FF->00
        do_load(8'hFD);
        bus.en = 1'b1; bus.up_down = 1'b0; bus.cks = 2'b00;
        step(1); expect_state("up2_e1", 8'hFD, 0, 0);
        step(1); expect_state("up2_e2", 8'hFE, 0, 0);
        step(2); expect_state("up2_e4", 8'hFF, 0, 0);
        step(1); expect_state("up2_e5", 8'hFF, 0, 0);
        step(1); expect_state("up2_e6_wrap", 8'h00, 1, 0);
        step(1); expect_state("up2_e7", 8'h00, 0, 0);

        // Down /16 through 00->FF
        do_load(8'h01);
        bus.en = 1'b1; bus.up_down = 1'b1; bus.cks = 2'b11;
        step(15); expect_state("dn16_e15", 8'h01, 0, 0);
        step(1);  expect_state("dn16_e16", 8'h00, 0, 0);
        step(15); expect_state("dn16_e31", 8'h00, 0, 0);
        step(1);  expect_state("dn16_e32_wrap", 8'hFF, 0, 1);
        step(1);  expect_state("dn16_e33", 8'hFF, 0, 0);

        // en toggle at /8 restarts the full period
        do_load(8'h00);
        bus.en = 1'b1; bus.up_down = 1'b0; bus.cks = 2'b10;
        step(3);
        bus.en = 1'b0;
        step(4); expect_state("en_off_frozen", 8'h00, 0, 0);
        bus.en = 1'b1;
        step(5); expect_state("reen_e5", 8'h00, 0, 0);
        step(2); expect_state("reen_e7", 8'h00, 0, 0);
        step(1); expect_state("reen_e8", 8'h01, 0, 0);

        // Load on the would-be wrap edge
        do_load(8'hFF);
        bus.en = 1'b1; bus.up_down = 1'b0; bus.cks = 2'b00;
        step(1); expect_state("pre_wrap", 8'hFF, 0, 0);
        bus.tdr = 8'h42; bus.load = 1'b1;
        step(1); expect_state("load_beats_wrap", 8'h42, 0, 0);
        bus.load = 1'b0;
        step(2); expect_state("count_after_load", 8'h43, 0, 0);

        // Asynchronous reset mid-count
        #2 presetn = 1'b0;
        #1 expect_state("async_reset", 0, 0, 0);
        @(negedge pclk);
        presetn = 1'b1;
        bus.en = 1'b0;

        // Randomized phase
        bus.en = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                bus.load = 1'b1;
                case ($urandom_range(0, 4))
                    0: bus.tdr = 8'h00;
                    1: bus.tdr = 8'h01;
                    2: bus.tdr = 8'hFE;
                    3: bus.tdr = 8'hFF;
                    default: bus.tdr = 8'($urandom);
                endcase
            end else begin
                bus.load = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 39) == 0) bus.up_down = ~bus.up_down;
            if ($urandom_range(0, 59) == 0) bus.cks = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) begin
                #2 presetn = 1'b0;
                @(negedge pclk);
                #2 presetn = 1'b1;
                @(negedge pclk);
            end else begin
                step(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_timer_counter_core
